// File: rtl/debug_unit_if.sv
// Signal bundle between the debug sequencer (master) and the UART, instruction
// memory, dump source and pipeline control it drives (slave).
interface debug_unit_if #(
  parameter int NBIT_DATA      = 8,
  parameter int INST_WIDTH     = 32,
  parameter int IMEM_ADDR_BITS = 10,
  parameter int DUMP_ADDR_BITS = 6
);
  logic                      rx_done_tick;
  logic [NBIT_DATA-1:0]      rx_data;
  logic                      tx_done_tick;
  logic                      tx_start;
  logic [NBIT_DATA-1:0]      tx_data;
  logic                      imem_we;
  logic [IMEM_ADDR_BITS-1:0] imem_addr;
  logic [INST_WIDTH-1:0]     imem_wdata;
  logic                      cpu_enable;
  logic                      cpu_reset;
  logic                      cpu_halt;
  logic [DUMP_ADDR_BITS-1:0] dump_addr;
  logic [INST_WIDTH-1:0]     dump_data;

  modport master (
    input  rx_done_tick, rx_data, tx_done_tick, cpu_halt, dump_data,
    output tx_start, tx_data, imem_we, imem_addr, imem_wdata,
           cpu_enable, cpu_reset, dump_addr
  );

  modport slave (
    output rx_done_tick, rx_data, tx_done_tick, cpu_halt, dump_data,
    input  tx_start, tx_data, imem_we, imem_addr, imem_wdata,
           cpu_enable, cpu_reset, dump_addr
  );
endinterface

// File: rtl/debug_unit.sv
// Host command sequencer: loads instruction memory from the UART, runs or
// single-steps the pipeline, and streams a block of processor state back.
//
// state        | meaning
// S_IDLE       | waiting for 'L', 'C' or 'S'
// S_LOAD       | assembling bytes into words, writing instruction memory
// S_RUN        | pipeline enabled until cpu_halt
// S_STEP       | pipeline frozen, 'N' steps once, 'Q' leaves
// S_STEP_PULSE | single enabled pipeline cycle
// S_DUMP_READ  | capture dump word k into the shift register
// S_DUMP_SEND  | pulse tx_start for the current byte
// S_DUMP_WAIT  | wait for the transmitter to finish the byte
module debug_unit #(
  parameter int NBIT_DATA      = 8,
  parameter int INST_WIDTH     = 32,
  parameter int IMEM_ADDR_BITS = 10,
  parameter int DUMP_ADDR_BITS = 6,
  parameter int DUMP_WORDS     = 40
) (
  input logic          CLK,
  input logic          RESET,
  debug_unit_if.master dbg
);
  localparam int BYTES_PER_WORD = INST_WIDTH / NBIT_DATA;
  localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
  localparam logic [DUMP_ADDR_BITS-1:0] LAST_WORD = DUMP_ADDR_BITS'(DUMP_WORDS - 1);
  localparam logic [NBIT_DATA-1:0] CMD_LOAD = NBIT_DATA'(8'h4C);
  localparam logic [NBIT_DATA-1:0] CMD_CONT = NBIT_DATA'(8'h43);
  localparam logic [NBIT_DATA-1:0] CMD_STEP = NBIT_DATA'(8'h53);
  localparam logic [NBIT_DATA-1:0] CMD_NEXT = NBIT_DATA'(8'h4E);
  localparam logic [NBIT_DATA-1:0] CMD_QUIT = NBIT_DATA'(8'h51);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_STEP, S_STEP_PULSE, S_DUMP_READ, S_DUMP_SEND, S_DUMP_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic                      ret_step_q, ret_step_d;
  logic                      rd_wait_q, rd_wait_d;
  logic [BCNT_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic                      imem_we_q, imem_we_d;
  logic [IMEM_ADDR_BITS-1:0] imem_addr_q, imem_addr_d;
  logic [INST_WIDTH-1:0]     imem_wdata_q, imem_wdata_d;
  logic [INST_WIDTH-1:0]     shift_q, shift_d;
  logic [DUMP_ADDR_BITS-1:0] dump_addr_q, dump_addr_d;
  logic [INST_WIDTH+NBIT_DATA-1:0] shift_in_wide;
  logic [INST_WIDTH-1:0]     shift_in;

  assign shift_in_wide = {shift_q, dbg.rx_data};
  assign shift_in      = shift_in_wide[INST_WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      ret_step_q   <= 1'b0;
      rd_wait_q    <= 1'b0;
      byte_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      shift_q      <= '0;
      dump_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      ret_step_q   <= ret_step_d;
      rd_wait_q    <= rd_wait_d;
      byte_cnt_q   <= byte_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      shift_q      <= shift_d;
      dump_addr_q  <= dump_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_step_d   = ret_step_q;
    rd_wait_d    = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    shift_d      = shift_q;
    dump_addr_d  = dump_addr_q;
    case (state_q)
      S_IDLE: begin
        if (dbg.rx_done_tick) begin
          if (dbg.rx_data == CMD_LOAD)      state_d = S_LOAD;
          else if (dbg.rx_data == CMD_CONT) state_d = S_RUN;
          else if (dbg.rx_data == CMD_STEP) state_d = S_STEP;
        end
      end
      S_LOAD: begin
        if (imem_we_q) begin
          if (imem_wdata_q == '1 || imem_addr_q == '1) begin
            imem_addr_d = '0;
            byte_cnt_d  = '0;
            state_d     = S_IDLE;
          end else begin
            imem_addr_d = imem_addr_q + 1'b1;
          end
        end else if (dbg.rx_done_tick) begin
          if (byte_cnt_q == LAST_BYTE) begin
            imem_wdata_d = shift_in;
            imem_we_d    = 1'b1;
            byte_cnt_d   = '0;
            shift_d      = '0;
          end else begin
            shift_d    = shift_in;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (dbg.cpu_halt) begin
          ret_step_d = 1'b0;
          state_d    = S_DUMP_READ;
        end
      end
      S_STEP: begin
        if (dbg.rx_done_tick) begin
          if (dbg.rx_data == CMD_NEXT)      state_d = S_STEP_PULSE;
          else if (dbg.rx_data == CMD_QUIT) state_d = S_IDLE;
        end
      end
      S_STEP_PULSE: begin
        ret_step_d = !dbg.cpu_halt;
        state_d    = S_DUMP_READ;
      end
      // After an address change the synchronous source needs one extra cycle.
      S_DUMP_READ: begin
        if (!rd_wait_q) begin
          shift_d = dbg.dump_data;
          state_d = S_DUMP_SEND;
        end
      end
      S_DUMP_SEND: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        if (dbg.tx_done_tick) begin
          shift_d = shift_q << NBIT_DATA;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (dump_addr_q == LAST_WORD) begin
              dump_addr_d = '0;
              state_d     = ret_step_q ? S_STEP : S_IDLE;
            end else begin
              dump_addr_d = dump_addr_q + 1'b1;
              rd_wait_d   = 1'b1;
              state_d     = S_DUMP_READ;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_DUMP_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg.tx_start   = (state_q == S_DUMP_SEND);
  assign dbg.tx_data    = shift_q[INST_WIDTH-1 -: NBIT_DATA];
  assign dbg.imem_we    = imem_we_q;
  assign dbg.imem_addr  = imem_addr_q;
  assign dbg.imem_wdata = imem_wdata_q;
  assign dbg.cpu_enable = (state_q == S_RUN && !dbg.cpu_halt) || (state_q == S_STEP_PULSE);
  assign dbg.cpu_reset  = (state_q == S_LOAD);
  assign dbg.dump_addr  = dump_addr_q;
endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: UART, dump-source and pipeline models plus a
// per-cycle checker of memory writes and transmitted bytes.
module tb_debug_unit;
  localparam int NB  = 8;
  localparam int IW  = 32;
  localparam int IAB = 2;
  localparam int DAB = 6;
  localparam int DW  = 6;
  localparam int TXD = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  debug_unit_if #(.NBIT_DATA(NB), .INST_WIDTH(IW), .IMEM_ADDR_BITS(IAB), .DUMP_ADDR_BITS(DAB)) dif ();

  debug_unit #(.NBIT_DATA(NB), .INST_WIDTH(IW), .IMEM_ADDR_BITS(IAB),
               .DUMP_ADDR_BITS(DAB), .DUMP_WORDS(DW)) dut (
    .CLK(CLK), .RESET(RESET), .dbg(dif.master));

  int cmp_cnt = 0;
  int err_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Host-side stimulus
  logic          rx_done = 1'b0;
  logic [NB-1:0] rx_data = '0;
  assign dif.rx_done_tick = rx_done;
  assign dif.rx_data      = rx_data;

  // Dump source: word k reads as 0xA5000000 + k, one cycle read latency
  logic [IW-1:0] dd = '0;
  always @(posedge CLK) dd <= 32'hA500_0000 + 32'(dif.dump_addr);
  assign dif.dump_data = dd;

  // Pipeline: halts once it has executed halt_after enabled cycles since en_base
  int en_cnt = 0;
  int en_base = 0;
  int halt_after = 0;
  bit halt_arm = 1'b0;
  always @(posedge CLK) if (dif.cpu_enable) en_cnt <= en_cnt + 1;
  assign dif.cpu_halt = halt_arm && ((en_cnt - en_base) >= halt_after);

  // UART transmitter: finishes each byte TXD cycles after tx_start
  int   tx_timer = 0;
  logic tx_done = 1'b0;
  always @(posedge CLK) begin
    if (RESET) begin
      tx_timer <= 0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (dif.tx_start) tx_timer <= TXD;
      else if (tx_timer > 0) begin
        if (tx_timer == 1) tx_done <= 1'b1;
        tx_timer <= tx_timer - 1;
      end
    end
  end
  assign dif.tx_done_tick = tx_done;

  // Expected traffic
  logic [NB-1:0]  exp_tx[$];
  logic [IAB-1:0] exp_wa[$];
  logic [IW-1:0]  exp_wd[$];
  int wr_cnt = 0;
  int tx_cnt = 0;
  bit busy = 1'b0;
  bit prev_start = 1'b0;
  logic [NB-1:0] held = '0;

  always @(negedge CLK) begin
    if (RESET) begin
      busy       = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (dif.imem_we) begin
        wr_cnt++;
        if (exp_wa.size() == 0) check("imem_we_unexpected", 1, 0);
        else begin
          check("imem_addr", dif.imem_addr, exp_wa.pop_front());
          check("imem_wdata", dif.imem_wdata, exp_wd.pop_front());
        end
      end
      if (dif.tx_start) begin
        tx_cnt++;
        if (prev_start) check("tx_start_width", 2, 1);
        if (exp_tx.size() == 0) check("tx_start_unexpected", 1, 0);
        else check("tx_data", dif.tx_data, exp_tx.pop_front());
        held = dif.tx_data;
        busy = 1'b1;
      end else if (busy && tx_done) begin
        check("tx_data_held", dif.tx_data, held);
        busy = 1'b0;
      end
      prev_start = dif.tx_start;
    end
  end

  task automatic push_dump();
    for (int k = 0; k < DW; k++) begin
      logic [IW-1:0] w;
      w = 32'hA500_0000 + 32'(k);
      for (int b = IW / NB - 1; b >= 0; b--) exp_tx.push_back(w[b*NB +: NB]);
    end
  endtask

  task automatic push_wr(input logic [IAB-1:0] a, input logic [IW-1:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic send_byte(input logic [NB-1:0] b);
    @(negedge CLK);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge CLK);
    rx_done = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic send_word(input logic [IW-1:0] w);
    for (int b = IW / NB - 1; b >= 0; b--) send_byte(w[b*NB +: NB]);
  endtask

  task automatic wait_dump(input string name);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) check(name, exp_tx.size(), 0);
    repeat (TXD + 6) @(negedge CLK);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, m, t0, seen;
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_tx_start", dif.tx_start, 0);
    check("rst_tx_data", dif.tx_data, 0);
    check("rst_imem_we", dif.imem_we, 0);
    check("rst_imem_addr", dif.imem_addr, 0);
    check("rst_imem_wdata", dif.imem_wdata, 0);
    check("rst_cpu_enable", dif.cpu_enable, 0);
    check("rst_cpu_reset", dif.cpu_reset, 0);
    check("rst_dump_addr", dif.dump_addr, 0);
    RESET = 1'b0;
    @(negedge CLK);

    // Load ending on HALT
    push_wr(2'd0, 32'h2008_0005);
    push_wr(2'd1, 32'hFFFF_FFFF);
    send_byte(8'h4C);
    check("load_cpu_reset", dif.cpu_reset, 1);
    send_word(32'h2008_0005);
    check("load_cpu_reset_mid", dif.cpu_reset, 1);
    send_word(32'hFFFF_FFFF);
    repeat (3) @(negedge CLK);
    check("load_writes", wr_cnt, 2);
    check("load_wdata_last", dif.imem_wdata, 32'hFFFF_FFFF);
    check("load_exit_cpu_reset", dif.cpu_reset, 0);
    check("load_exit_addr", dif.imem_addr, 0);

    // Load ending at the last address; fifth word falls into IDLE
    push_wr(2'd0, 32'h0102_0304);
    push_wr(2'd1, 32'h0506_0708);
    push_wr(2'd2, 32'h090A_0B0C);
    push_wr(2'd3, 32'h0D0E_0F10);
    send_byte(8'h4C);
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    send_word(32'h090A_0B0C);
    send_word(32'h0D0E_0F10);
    check("wrap_exit_cpu_reset", dif.cpu_reset, 0);
    send_word(32'h1112_1314);
    repeat (3) @(negedge CLK);
    check("wrap_writes", wr_cnt, 6);
    check("wrap_pending", exp_wa.size(), 0);

    // Continuous run, halt after 7 enabled cycles
    en_base = en_cnt;
    halt_after = 7;
    halt_arm = 1'b1;
    push_dump();
    t0 = tx_cnt;
    @(negedge CLK);
    rx_data = 8'h43;
    rx_done = 1'b1;
    @(negedge CLK);
    rx_done = 1'b0;
    check("run_enable_first", dif.cpu_enable, 1);
    n = 0;
    while (!dif.cpu_halt && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("run_halt_seen", n < 100, 1);
    check("run_enable_at_halt", dif.cpu_enable, 0);
    m = 0;
    while (!dif.tx_start && m < 20) begin
      @(negedge CLK);
      m++;
    end
    check("halt_to_tx_start", m, 2);
    check("run_first_byte", dif.tx_data, 8'hA5);
    wait_dump("run_dump_timeout");
    check("run_enable_cycles", en_cnt - en_base, 7);
    check("run_bytes", tx_cnt - t0, DW * 4);
    halt_arm = 1'b0;

    // Step mode: two steps, bytes during a dump dropped, then quit
    en_base = en_cnt;
    push_dump();
    send_byte(8'h53);
    send_byte(8'h4E);
    send_byte(8'h51);
    send_byte(8'h4E);
    wait_dump("step1_dump_timeout");
    check("step1_enable", en_cnt - en_base, 1);
    push_dump();
    send_byte(8'h4E);
    wait_dump("step2_dump_timeout");
    check("step2_enable", en_cnt - en_base, 2);
    send_byte(8'h51);
    send_byte(8'h4E);
    repeat (10) @(negedge CLK);
    check("step_quit_enable", en_cnt - en_base, 2);

    // Step straight into a halt: dump then IDLE, next 'N' ignored
    en_base = en_cnt;
    halt_after = 0;
    halt_arm = 1'b1;
    push_dump();
    send_byte(8'h53);
    send_byte(8'h4E);
    wait_dump("stephalt_dump_timeout");
    check("stephalt_enable", en_cnt - en_base, 1);
    send_byte(8'h4E);
    repeat (10) @(negedge CLK);
    check("stephalt_n_ignored", en_cnt - en_base, 1);
    halt_arm = 1'b0;

    // Reset after five dump bytes
    en_base = en_cnt;
    halt_after = 3;
    halt_arm = 1'b1;
    push_dump();
    t0 = tx_cnt;
    send_byte(8'h43);
    n = 0;
    while ((tx_cnt - t0) < 5 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("rstdump_five_bytes", tx_cnt - t0, 5);
    RESET = 1'b1;
    halt_arm = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    exp_tx.delete();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dif.tx_start) seen++;
      @(negedge CLK);
    end
    check("rstdump_tx_quiet", seen, 0);
    check("rstdump_enable", dif.cpu_enable, 0);
    check("rstdump_cpu_reset", dif.cpu_reset, 0);
    check("rstdump_dump_addr", dif.dump_addr, 0);
    en_base = en_cnt;
    halt_after = 2;
    halt_arm = 1'b1;
    push_dump();
    send_byte(8'h43);
    n = 0;
    while (!dif.tx_start && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("rerun_dump_addr", dif.dump_addr, 0);
    check("rerun_first_byte", dif.tx_data, 8'hA5);
    wait_dump("rerun_dump_timeout");
    check("rerun_enable", en_cnt - en_base, 2);
    halt_arm = 1'b0;
    repeat (5) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
